// File: rtl/campus_bus_scheduler_if.sv
// Scheduler-to-students bundle: level requests in, boarding and drop-off status out.
// Latency: none, wires only.
// Backpressure: none; requests are level-held by the students until served.
interface campus_bus_scheduler_if #(
    parameter int N_STUDENTS = 4,
    parameter int CAPACITY   = 2
);
    localparam int CW = $clog2(CAPACITY + 1);

    logic [N_STUDENTS-1:0] req;
    logic [N_STUDENTS-1:0] bus;
    logic [N_STUDENTS-1:0] arrive;
    logic [N_STUDENTS-1:0] riding;
    logic [CW-1:0]         count;
    logic [1:0]            state_out;
    logic                  busy;

    // Student side: raises requests, watches the bus.
    modport master (
        output req,
        input  bus, arrive, riding, count, state_out, busy
    );

    // Scheduler side.
    modport slave (
        input  req,
        output bus, arrive, riding, count, state_out, busy
    );
endinterface

// File: rtl/campus_bus_scheduler.sv
// Round-robin trip scheduler sharing one bus of CAPACITY seats among N students.
// Latency: first bus pulse two edges after req rises in IDLE, then at most one grant per cycle.
// Backpressure: no stall input; requests seen during TRAVEL/UNLOAD wait for the next trip.
module campus_bus_scheduler #(
    parameter int N_STUDENTS    = 4,
    parameter int CAPACITY      = 2,
    parameter int TRAVEL_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    campus_bus_scheduler_if.slave sb
);
    localparam int PW = (N_STUDENTS > 1) ? $clog2(N_STUDENTS) : 1;
    localparam int CW = $clog2(CAPACITY + 1);
    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] CAP        = CW'(CAPACITY);
    localparam logic [PW-1:0] LAST_IDX   = PW'(N_STUDENTS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOARD  = 2'd1,
        TRAVEL = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Registered outputs and their next values.
    logic [N_STUDENTS-1:0] grant_pulse, grant_pulse_nxt;
    logic [N_STUDENTS-1:0] drop_mask,   drop_mask_nxt;
    logic [N_STUDENTS-1:0] rider_mask,  rider_mask_nxt;
    logic [CW-1:0]         rider_count, rider_count_nxt;
    logic                  busy_flag;

    // Internal state.
    logic [PW-1:0]         rr_ptr, rr_ptr_nxt;
    logic [TW-1:0]         timer,  timer_nxt;

    // Grant selection.
    logic [N_STUDENTS-1:0] eligible;
    logic [N_STUDENTS-1:0] grant_oh;
    logic [PW-1:0]         grant_idx;
    logic                  grant_vld;
    logic                  last_seat;
    logic [PW:0]           scan_idx;

    // Pick the first eligible student at or after rr_ptr, wrapping; riders are never eligible.
    always_comb begin
        eligible  = sb.req & ~rider_mask;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_STUDENTS; k++) begin
            scan_idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(N_STUDENTS)) begin
                scan_idx = scan_idx - (PW+1)'(N_STUDENTS);
            end
            if (!grant_vld && eligible[scan_idx[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[PW-1:0];
            end
        end
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
        // Depart once the bus is full or nobody else is left waiting.
        last_seat = (rider_count + CW'(1) == CAP) || ((eligible & ~grant_oh) == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|sb.req) begin
                    state_nxt = BOARD;
                end
            end
            BOARD: begin
                if (grant_vld) begin
                    if (last_seat) begin
                        state_nxt = TRAVEL;
                    end
                end else begin
                    // Everyone withdrew: leave with whoever boarded, or give up the trip.
                    state_nxt = (rider_count != '0) ? TRAVEL : IDLE;
                end
            end
            TRAVEL: begin
                if (timer == '0) begin
                    state_nxt = UNLOAD;
                end
            end
            UNLOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, pointer and travel timer.
    always_comb begin
        grant_pulse_nxt = '0;
        drop_mask_nxt   = '0;
        rider_mask_nxt  = rider_mask;
        rider_count_nxt = rider_count;
        rr_ptr_nxt      = rr_ptr;
        timer_nxt       = timer;
        case (state)
            BOARD: begin
                if (grant_vld) begin
                    grant_pulse_nxt = grant_oh;
                    rider_mask_nxt  = rider_mask | grant_oh;
                    rider_count_nxt = rider_count + CW'(1);
                    rr_ptr_nxt      = (grant_idx == LAST_IDX) ? '0 : grant_idx + PW'(1);
                end
                if (state_nxt == TRAVEL) begin
                    timer_nxt = TIMER_LOAD;
                end
            end
            TRAVEL: begin
                if (timer == '0) begin
                    drop_mask_nxt = rider_mask;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            UNLOAD: begin
                rider_mask_nxt  = '0;
                rider_count_nxt = '0;
            end
            default: begin
            end
        endcase
    end

    // Output, pointer and timer registers; reset drops all riders without an arrive pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_pulse <= '0;
            drop_mask   <= '0;
            rider_mask  <= '0;
            rider_count <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            busy_flag   <= 1'b0;
        end else begin
            grant_pulse <= grant_pulse_nxt;
            drop_mask   <= drop_mask_nxt;
            rider_mask  <= rider_mask_nxt;
            rider_count <= rider_count_nxt;
            rr_ptr      <= rr_ptr_nxt;
            timer       <= timer_nxt;
            busy_flag   <= (state_nxt != IDLE);
        end
    end

    assign sb.bus       = grant_pulse;
    assign sb.arrive    = drop_mask;
    assign sb.riding    = rider_mask;
    assign sb.count     = rider_count;
    assign sb.state_out = state;
    assign sb.busy      = busy_flag;
endmodule
